// File: rtl/tf530_fastram_ctrl.sv
// TF530 local fast-RAM cycle controller: claims 68030 cycles in the fast-RAM window,
// drives SRAM strobes and byte lanes, and terminates with 32-bit DSACK after WAITSTATES.
`timescale 1ns/1ps
module tf530_fastram_ctrl #(
    parameter int unsigned WAITSTATES = 1,
    parameter logic [2:0]  RAM_LO     = 3'd1,
    parameter logic [2:0]  RAM_HI     = 3'd4
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW20,
    input  logic [2:0]  FC,
    input  logic [1:0]  SIZ,
    input  logic [23:0] A,
    input  logic        BGACK,
    input  logic        RAMEN,
    output logic        INTCYCLE,
    output logic [1:0]  DSACK,
    output logic        RAMCS,
    output logic        RAMOE,
    output logic        RAMWE,
    output logic [3:0]  BE
);

    typedef enum logic [1:0] {IDLE, MISS, WAIT, ACK} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        as_d;
    logic [3:0]  be_q, be_next, be_calc;
    logic        rd_q, rd_next;
    logic        we_q, we_next;
    logic        start, hit, in_cycle;
    logic [2:0]  nbytes;
    logic [3:0]  last_lane;
    logic        unused_addr;

    assign unused_addr = ^A[20:2];

    always_comb begin
        start = as_d & ~AS20;
        hit   = start & RAMEN & BGACK & (FC != 3'b111)
              & (A[23:21] >= RAM_LO) & (A[23:21] <= RAM_HI);
    end

    // Lane 0 is D31:24; lanes past 3 simply fall off the end of the port.
    always_comb begin
        nbytes    = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
        last_lane = {2'b00, A[1:0]} + {1'b0, nbytes} - 4'd1;
        be_calc   = '1;
        for (int unsigned k = 0; k < 4; k++) begin
            if (({2'b00, A[1:0]} <= 4'(k)) && (4'(k) <= last_lane))
                be_calc[2'(3 - k)] = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        be_next    = be_q;
        rd_next    = rd_q;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next = WAIT;
                    cnt_next   = 4'(WAITSTATES);
                    be_next    = be_calc;
                    rd_next    = RW20;
                end else if (start) begin
                    state_next = MISS;
                end
            end
            MISS: if (AS20) state_next = IDLE;
            WAIT: begin
                if (AS20)
                    state_next = IDLE;
                else if (cnt == 4'd0)
                    state_next = ACK;
                else
                    cnt_next = cnt - 4'd1;
            end
            ACK: if (AS20) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        we_next = ((state_next == WAIT) || (state_next == ACK)) & ~RW20 & ~DS20;
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
            as_d  <= 1'b1;
            be_q  <= '1;
            rd_q  <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            as_d  <= AS20;
            be_q  <= be_next;
            rd_q  <= rd_next;
            we_q  <= we_next;
        end
    end

    assign in_cycle = (state == WAIT) || (state == ACK);
    assign INTCYCLE = ~in_cycle;
    assign RAMCS    = ~in_cycle;
    assign RAMOE    = ~(in_cycle & rd_q);
    assign RAMWE    = ~we_q;
    assign BE       = in_cycle ? be_q : 4'b1111;
    assign DSACK    = (state == ACK)  ? 2'b00 :
                      (state == WAIT) ? 2'b11 : 2'bzz;

endmodule
